seq_lfsr_range_sampler: RTL and testbench
=========================================

# seq_lfsr_range_sampler

Downstream consumer of the 5-bit maximal-length LFSR stage. Every cycle it samples the LFSR's 5-bit output and applies rejection sampling, producing samples uniformly distributed over `[0, LIMIT-1]`. Accepted samples are buffered in a 2-entry queue and presented on a val/rdy output stream. Samples arriving while the queue cannot accept them are dropped and counted in a saturating drop counter.

## Interface
- `LIMIT`, default 20: number of output symbols; legal range 1..31.
- `clk`  input  1: clock; all state updates on the rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `en`  input  1: sample enable; when 0, `in` is ignored that cycle.
- `in`  input  5: LFSR output; a new value every cycle.
- `out_val`  output  1: output stream valid.
- `out_rdy`  input  1: output stream ready.
- `out_msg`  output  5: sample value, `in - 1`, zero-extended; always `< LIMIT`.
- `drop_clear`  input  1: synchronous clear of `drop_count`.
- `drop_count`  output  8: saturating count of accepted-but-dropped samples.

## Operation
- **Acceptance:** a sample is accepted when `en=1` and `1 <= in <= LIMIT`.
  - `in=0` (the LFSR lock-up state) is always rejected.
  - `in > LIMIT` is rejected.
  - Rejected samples have no effect on any state.
- **Enqueue/drop:** an accepted sample is enqueued as `in-1` if `count<2`, or if `count==2` and a dequeue occurs in the same cycle (`out_val & out_rdy`). Otherwise it is dropped and `drop_count` increments.
- **Queue behaviour:**
  - FIFO order.
  - `out_val = (count != 0)`.
  - `out_msg` = head entry; when the queue is empty, `out_msg` is 0.
  - Dequeue happens when `out_val & out_rdy`.
- **Occupancy update:** `count` takes values 0, 1, 2.
  - Enqueue only: `count+1`.
  - Dequeue only: `count-1`.
  - Both: `count` unchanged.
  - When both occur at `count==1`, the new entry becomes the head.
- **drop_count:**
  - Saturates at 255.
  - `drop_clear` takes priority over a same-cycle drop; the result is 0.
- **Reset values:** `count=0`, `out_val=0`, `out_msg=0`, `drop_count=0`, all queue entries 0.

## Timing
- **Latency:** a sample accepted at rising edge N is visible on `out_val`/`out_msg` after edge N. The output is registered; there is no combinational path from `in` or `en` to `out_*`.
- **No ready-to-valid path:** `out_rdy` does not combinationally affect `out_val` or `out_msg`. It only affects the enqueue/drop decision, as the full-with-dequeue pass case.
- **Throughput:** one sample per cycle in and out when `out_rdy` is held high.
- **Reset mid-operation:** `reset_n` low forces all outputs to reset values immediately, without waiting for a clock edge. Queued samples are lost and are not counted as drops. The first edge after release behaves as a normal cycle.
- **drop_clear timing:** `drop_count` reads 0 after the edge on which `drop_clear=1`.

## Structure
- Shared package `lfsr_pkg`:
  - constant `LFSR_NBITS=5`;
  - constant `SAMPLE_Q_DEPTH=2`;
  - typedef `lfsr_word_t` (`logic [4:0]`).
- Sub-module `lfsr_sample_queue`: a 2-entry val/rdy FIFO with an `enq_en` / `full` / `deq` interface. Pass-when-full-and-dequeuing is handled inside it.
- Top level: accept/reject comparator, drop logic, saturating counter.

## Test plan
- **Basic accept:** reset, then `en=1`, `in=5`, `out_rdy=1` for one cycle, then `en=0` → next cycle `out_val=1`, `out_msg=4`; the following cycle `out_val=0`.
- **Bounds (LIMIT=20):**
  - `in=20` → `out_msg=19`.
  - `in=21` → no output and `drop_count` stays 0.
  - `in=0` → no output.
  - `en=0` with `in=3` → no output.
- **Backpressure:** `out_rdy=0`; push 3, 7, 9 on consecutive cycles → `count=2`, `drop_count=1`. Then `out_rdy=1` → outputs 2 then 6, then `out_val=0`.
- **Full with dequeue:** queue full, `out_rdy=1`, push `in=11` → no drop, `count` stays 2, output order preserved, 10 emitted last.
- **Saturation and clear:** force 300 drops → `drop_count=255`. Assert `drop_clear` in the same cycle as a drop → 0.
- **Async reset:** with 2 entries queued, pull `reset_n` low mid-cycle → `out_val=0` and `drop_count=0` before the next edge. After release, the `in=5` accept → `out_msg=4`.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sampling stages.
// Contents:
//   LFSR_NBITS     - width of an LFSR output word
//   SAMPLE_Q_DEPTH - depth of the accepted-sample queue
//   lfsr_word_t    - one LFSR output word
//   in_window()    - rejection-sampling acceptance test
package lfsr_pkg;

  localparam int LFSR_NBITS     = 5;
  localparam int SAMPLE_Q_DEPTH = 2;

  typedef logic [LFSR_NBITS-1:0] lfsr_word_t;

  // True when v lies in [1, lim]. Zero is the LFSR lock-up state and is never a sample.
  function automatic logic in_window(lfsr_word_t v, lfsr_word_t lim);
    return (v != lfsr_word_t'(0)) && (v <= lim);
  endfunction

endpackage

// File: rtl/lfsr_sample_queue.sv
// Two-entry val/rdy FIFO for accepted samples.
// Ports:
//   clk, reset_n      - clock, asynchronous active-low reset
//   enq_en, enq_data  - offer a sample; taken if not full or if dequeuing
//   full              - queue holds two entries
//   deq               - a dequeue happens this cycle (deq_val & deq_rdy)
//   deq_val, deq_data - head of queue; deq_data is 0 when empty
//   deq_rdy           - consumer ready
module lfsr_sample_queue
  import lfsr_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enq_en,
  input  lfsr_word_t enq_data,
  output logic       full,
  output logic       deq,
  output logic       deq_val,
  output lfsr_word_t deq_data,
  input  logic       deq_rdy
);

  logic [1:0] count;
  logic [1:0] count_next;
  lfsr_word_t q0;
  lfsr_word_t q1;
  lfsr_word_t q0_next;
  lfsr_word_t q1_next;
  logic       enq;

  // Outputs come straight from flops, so deq_rdy never reaches deq_val/deq_data.
  assign deq_val  = (count != 2'd0);
  assign deq_data = q0;
  assign full     = (count == 2'(SAMPLE_Q_DEPTH));
  assign deq      = deq_val & deq_rdy;
  assign enq      = enq_en & (~full | deq);

  // Next-state for occupancy and entries; q0 is always the head, cleared when vacated.
  always_comb begin
    count_next = count;
    q0_next    = q0;
    q1_next    = q1;
    case ({enq, deq})
      2'b10: begin
        count_next = count + 2'd1;
        if (count == 2'd0) begin
          q0_next = enq_data;
        end else begin
          q1_next = enq_data;
        end
      end
      2'b01: begin
        count_next = count - 2'd1;
        if (count == 2'd2) begin
          q0_next = q1;
        end else begin
          q0_next = lfsr_word_t'(0);
        end
        q1_next = lfsr_word_t'(0);
      end
      2'b11: begin
        // Occupancy unchanged; at one entry the newcomer becomes the head.
        if (count == 2'd2) begin
          q0_next = q1;
          q1_next = enq_data;
        end else begin
          q0_next = enq_data;
        end
      end
      default: begin
        count_next = count;
      end
    endcase
  end

  // Queue state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 2'd0;
      q0    <= lfsr_word_t'(0);
      q1    <= lfsr_word_t'(0);
    end else begin
      count <= count_next;
      q0    <= q0_next;
      q1    <= q1_next;
    end
  end

endmodule

// File: rtl/seq_lfsr_range_sampler.sv
// Rejection sampler over a 5-bit LFSR stream: emits uniform samples in
// [0, LIMIT-1] through a 2-entry queue, counting samples lost to a full queue.
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   en, in              - sample enable and LFSR word
//   out_val/out_rdy/out_msg - output stream (out_msg = in-1, 0 when idle)
//   drop_clear          - synchronous clear of drop_count (wins over a drop)
//   drop_count          - saturating count of accepted-but-dropped samples
module seq_lfsr_range_sampler
  import lfsr_pkg::*;
#(
  parameter int LIMIT = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  lfsr_word_t in,
  output logic       out_val,
  input  logic       out_rdy,
  output lfsr_word_t out_msg,
  input  logic       drop_clear,
  output logic [7:0] drop_count
);

  logic accept;
  logic full;
  logic deq;
  logic drop;

  assign accept = en & in_window(in, lfsr_word_t'(LIMIT));
  assign drop   = accept & full & ~deq;

  lfsr_sample_queue u_queue (
    .clk      (clk),
    .reset_n  (reset_n),
    .enq_en   (accept),
    .enq_data (in - lfsr_word_t'(1)),
    .full     (full),
    .deq      (deq),
    .deq_val  (out_val),
    .deq_data (out_msg),
    .deq_rdy  (out_rdy)
  );

  // Saturating drop counter; clear takes priority over a same-cycle drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= 8'd0;
    end else if (drop_clear) begin
      drop_count <= 8'd0;
    end else if (drop && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end else begin
      drop_count <= drop_count;
    end
  end

endmodule

// File: tb/tb_seq_lfsr_range_sampler.sv
// Self-checking bench for seq_lfsr_range_sampler (LIMIT=20): directed steps
// followed by random traffic, compared against a queue-based reference model.
module tb_seq_lfsr_range_sampler;

  localparam int LIMIT = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [4:0] in_w;
  logic       out_val;
  logic       out_rdy;
  logic [4:0] out_msg;
  logic       drop_clear;
  logic [7:0] drop_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: plain queue of sample values plus a drop tally.
  int mq[$];
  int mdrop = 0;

  seq_lfsr_range_sampler #(.LIMIT(LIMIT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .in         (in_w),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_msg    (out_msg),
    .drop_clear (drop_clear),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_val"}, {31'd0, out_val}, (mq.size() != 0) ? 32'd1 : 32'd0);
    check({tag, ".out_msg"}, {27'd0, out_msg}, (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    check({tag, ".drop_count"}, {24'd0, drop_count}, 32'(mdrop));
  endtask

  // One cycle: drive inputs, advance the model at the edge, compare just after it.
  task automatic step(input logic e, input int v, input logic rdy, input logic clr, input string tag);
    bit acc, deq;
    int sz;
    en = e; in_w = 5'(v); out_rdy = rdy; drop_clear = clr;
    @(posedge clk);
    sz  = mq.size();
    deq = (sz != 0) && rdy;
    acc = e && (v >= 1) && (v <= LIMIT);
    if (deq) void'(mq.pop_front());
    if (clr) mdrop = 0;
    if (acc) begin
      if (sz < 2 || deq) mq.push_back(v - 1);
      else if (!clr && mdrop < 255) mdrop++;
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; in_w = 5'd0; out_rdy = 1'b0; drop_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    reset_n = 1'b1;

    // Basic accept and single-cycle presence
    step(1'b1, 5, 1'b1, 1'b0, "basic_acc");
    step(1'b0, 5, 1'b1, 1'b0, "basic_gone");

    // Bounds
    step(1'b1, 20, 1'b1, 1'b0, "in20");
    step(1'b1, 21, 1'b1, 1'b0, "in21");
    step(1'b1, 0,  1'b1, 1'b0, "in0");
    step(1'b0, 3,  1'b1, 1'b0, "en0");

    // Backpressure: third push dropped, then drain
    step(1'b1, 3, 1'b0, 1'b0, "bp3");
    step(1'b1, 7, 1'b0, 1'b0, "bp7");
    step(1'b1, 9, 1'b0, 1'b0, "bp9");
    // out_rdy must not change outputs combinationally
    out_rdy = 1'b1; #1;
    check_outputs("rdy_no_comb");
    step(1'b0, 0, 1'b1, 1'b0, "drain1");
    step(1'b0, 0, 1'b1, 1'b0, "drain2");
    step(1'b0, 0, 1'b1, 1'b0, "drain_empty");

    // Full with same-cycle dequeue passes the new sample
    step(1'b1, 3,  1'b0, 1'b0, "fd_fill1");
    step(1'b1, 7,  1'b0, 1'b0, "fd_fill2");
    step(1'b1, 11, 1'b1, 1'b0, "fd_pass");
    step(1'b0, 0,  1'b1, 1'b0, "fd_out6");
    step(1'b0, 0,  1'b1, 1'b0, "fd_out10");
    step(1'b0, 0,  1'b1, 1'b0, "fd_empty");

    // Saturation and clear-over-drop
    for (int i = 0; i < 302; i++) step(1'b1, 1, 1'b0, 1'b0, "sat");
    check("sat_255", {24'd0, drop_count}, 32'd255);
    step(1'b1, 1, 1'b0, 1'b1, "clr_vs_drop");
    check("clr_zero", {24'd0, drop_count}, 32'd0);
    step(1'b1, 2, 1'b0, 1'b0, "post_clr_drop");

    // Async reset mid-cycle with a full queue
    #2 reset_n = 1'b0;
    #1;
    mq.delete(); mdrop = 0;
    check_outputs("async_rst");
    @(posedge clk); #1;
    check_outputs("rst_held");
    reset_n = 1'b1;
    step(1'b1, 5, 1'b1, 1'b0, "after_rst");
    step(1'b0, 0, 1'b1, 1'b0, "after_rst_idle");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
